// File: rtl/jtag_sys_reset_ctrl.sv
// System-clock reset sequencer: synchronizes the JTAG reset request and DDR3 calibration flag,
// holds the core in reset for a minimum time, then waits for calibration before releasing it.
module jtag_sys_reset_ctrl #(
  parameter int unsigned HOLD_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1048576,
  parameter int unsigned CNT_WIDTH      = 24
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       jsys_reset,
  input  logic       init_ddr3_done,
  output logic       core_reset,
  output logic [1:0] sys_state,
  output logic       ddr_timeout,
  output logic [7:0] reset_count
);

  typedef enum logic [1:0] {
    ST_ASSERT   = 2'd0,
    ST_WAIT_DDR = 2'd1,
    ST_RUN      = 2'd2
  } state_e;

  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_LAST  = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  logic                 jreq_meta_q, jreq_s_q, jreq_d_q;
  logic                 ddr_meta_q, ddr_s_q;
  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 core_reset_q;
  logic [1:0]           sys_state_q;
  logic                 ddr_timeout_q, ddr_timeout_d;
  logic [7:0]           reset_count_q, reset_count_d;
  logic                 req_rise;

  assign req_rise = jreq_s_q & ~jreq_d_q;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    ddr_timeout_d = ddr_timeout_q;
    reset_count_d = reset_count_q;
    if (jreq_s_q) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          if (cnt_q == HOLD_LAST) begin
            state_d = ST_WAIT_DDR;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_DDR: begin
          if (ddr_s_q) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else if (cnt_q < TMO_LAST) begin
            cnt_d = cnt_q + CNT_ONE;
          end else begin
            ddr_timeout_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (!ddr_s_q) begin
            state_d = ST_ASSERT;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = ST_ASSERT;
          cnt_d   = '0;
        end
      endcase
    end
    // A new request overrides a same-cycle timeout.
    if (req_rise) begin
      ddr_timeout_d = 1'b0;
      if (reset_count_q != '1) reset_count_d = reset_count_q + 8'd1;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      jreq_meta_q   <= 1'b0;
      jreq_s_q      <= 1'b0;
      jreq_d_q      <= 1'b0;
      ddr_meta_q    <= 1'b0;
      ddr_s_q       <= 1'b0;
      state_q       <= ST_ASSERT;
      cnt_q         <= '0;
      core_reset_q  <= 1'b1;
      sys_state_q   <= 2'd0;
      ddr_timeout_q <= 1'b0;
      reset_count_q <= '0;
    end else begin
      jreq_meta_q   <= jsys_reset;
      jreq_s_q      <= jreq_meta_q;
      jreq_d_q      <= jreq_s_q;
      ddr_meta_q    <= init_ddr3_done;
      ddr_s_q       <= ddr_meta_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      core_reset_q  <= (state_d != ST_RUN);
      sys_state_q   <= state_d;
      ddr_timeout_q <= ddr_timeout_d;
      reset_count_q <= reset_count_d;
    end
  end

  assign core_reset  = core_reset_q;
  assign sys_state   = sys_state_q;
  assign ddr_timeout = ddr_timeout_q;
  assign reset_count = reset_count_q;

endmodule

// File: tb/tb_jtag_sys_reset_ctrl.sv
// Directed bench for jtag_sys_reset_ctrl: expectations are queued with the edge number at
// which they must hold and compared on the following falling edge.
module tb_jtag_sys_reset_ctrl;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       jsys_reset;
  logic       init_ddr3_done;
  logic       core_reset;
  logic [1:0] sys_state;
  logic       ddr_timeout;
  logic [7:0] reset_count;

  jtag_sys_reset_ctrl #(
    .HOLD_CYCLES   (16),
    .TIMEOUT_CYCLES(64),
    .CNT_WIDTH     (24)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_rst_n     (sys_rst_n),
    .jsys_reset    (jsys_reset),
    .init_ddr3_done(init_ddr3_done),
    .core_reset    (core_reset),
    .sys_state     (sys_state),
    .ddr_timeout   (ddr_timeout),
    .reset_count   (reset_count)
  );

  typedef enum {SIG_CORE, SIG_STATE, SIG_TMO, SIG_CNT} sig_e;
  typedef struct {
    int         at;
    sig_e       sig;
    logic [7:0] val;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   cyc        = 0;
  int   compared   = 0;
  int   mismatched = 0;

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  function automatic logic [7:0] observe(sig_e s);
    case (s)
      SIG_CORE:  return {7'd0, core_reset};
      SIG_STATE: return {6'd0, sys_state};
      SIG_TMO:   return {7'd0, ddr_timeout};
      default:   return reset_count;
    endcase
  endfunction

  function automatic void compare(string tag, logic [7:0] obs, logic [7:0] exp_v);
    compared++;
    assert (obs === exp_v)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endfunction

  function automatic void expect_at(int at, sig_e s, logic [7:0] v, string tag);
    sb.push_back('{at, s, v, tag});
  endfunction

  always @(negedge sys_clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].at == cyc) begin
        compare($sformatf("%s@%0d", sb[i].tag, cyc), observe(sb[i].sig), sb[i].val);
        sb.delete(i);
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  // Reset released just after edge c0; with calibration done, RUN arrives at edge c0+17.
  task automatic expect_powerup(int c0, string p);
    expect_at(c0 + 1,  SIG_STATE, 8'd0, {p, "_state_assert"});
    expect_at(c0 + 15, SIG_STATE, 8'd0, {p, "_state_assert_end"});
    expect_at(c0 + 16, SIG_STATE, 8'd1, {p, "_state_wait"});
    expect_at(c0 + 16, SIG_CORE,  8'd1, {p, "_core_hold"});
    expect_at(c0 + 17, SIG_STATE, 8'd2, {p, "_state_run"});
    expect_at(c0 + 17, SIG_CORE,  8'd0, {p, "_core_release"});
    expect_at(c0 + 17, SIG_CNT,   8'd0, {p, "_count"});
    expect_at(c0 + 17, SIG_TMO,   8'd0, {p, "_tmo"});
  endtask

  initial begin
    int c0, k, c;
    sys_rst_n      = 1'b0;
    jsys_reset     = 1'b0;
    init_ddr3_done = 1'b1;
    tick(3);
    compare("rst_core",  {7'd0, core_reset}, 8'd1);
    compare("rst_state", {6'd0, sys_state},  8'd0);
    compare("rst_tmo",   {7'd0, ddr_timeout}, 8'd0);
    compare("rst_count", reset_count,         8'd0);

    // 1: power-up
    sys_rst_n = 1'b1;
    c0 = cyc;
    expect_powerup(c0, "pwr1");
    tick(20);

    // 2: JTAG reset while running, held 40 cycles
    k = cyc + 1;
    jsys_reset = 1'b1;
    expect_at(k + 1,  SIG_CORE,  8'd0, "jreq_core_still_run");
    expect_at(k + 1,  SIG_CNT,   8'd0, "jreq_count_before");
    expect_at(k + 2,  SIG_CORE,  8'd1, "jreq_core_assert");
    expect_at(k + 2,  SIG_STATE, 8'd0, "jreq_state_assert");
    expect_at(k + 2,  SIG_CNT,   8'd1, "jreq_count_once");
    expect_at(k + 30, SIG_CNT,   8'd1, "jreq_count_held");
    expect_at(k + 57, SIG_CORE,  8'd1, "jreq_core_hold_end");
    expect_at(k + 57, SIG_STATE, 8'd1, "jreq_state_wait");
    expect_at(k + 58, SIG_CORE,  8'd0, "jreq_core_release");
    expect_at(k + 58, SIG_STATE, 8'd2, "jreq_state_run");
    tick(40);
    jsys_reset = 1'b0;
    tick(25);

    // 3: DDR timeout, late calibration, then a request clears the flag
    sys_rst_n      = 1'b0;
    init_ddr3_done = 1'b0;
    tick(2);
    sys_rst_n = 1'b1;
    c0 = cyc;
    expect_at(c0 + 16, SIG_STATE, 8'd1, "tmo_state_wait");
    expect_at(c0 + 79, SIG_TMO,   8'd0, "tmo_not_yet");
    expect_at(c0 + 80, SIG_TMO,   8'd1, "tmo_set");
    expect_at(c0 + 80, SIG_CORE,  8'd1, "tmo_core_held");
    expect_at(c0 + 80, SIG_STATE, 8'd1, "tmo_state_still_wait");
    tick(85);
    k = cyc + 1;
    init_ddr3_done = 1'b1;
    expect_at(k + 1, SIG_STATE, 8'd1, "late_state_wait");
    expect_at(k + 2, SIG_STATE, 8'd2, "late_state_run");
    expect_at(k + 2, SIG_CORE,  8'd0, "late_core_release");
    expect_at(k + 2, SIG_TMO,   8'd1, "late_tmo_sticky");
    tick(5);
    k = cyc + 1;
    jsys_reset = 1'b1;
    expect_at(k + 1, SIG_TMO, 8'd1, "clr_tmo_before");
    expect_at(k + 1, SIG_CNT, 8'd0, "clr_count_before");
    expect_at(k + 2, SIG_TMO, 8'd0, "clr_tmo_cleared");
    expect_at(k + 2, SIG_CNT, 8'd1, "clr_count_inc");
    tick(4);
    jsys_reset = 1'b0;
    tick(30);

    // 4: calibration lost for 10 cycles while running
    k = cyc + 1;
    init_ddr3_done = 1'b0;
    expect_at(k + 1,  SIG_CORE,  8'd0, "loss_core_run");
    expect_at(k + 2,  SIG_CORE,  8'd1, "loss_core_assert");
    expect_at(k + 2,  SIG_STATE, 8'd0, "loss_state_assert");
    expect_at(k + 17, SIG_STATE, 8'd0, "loss_state_hold");
    expect_at(k + 18, SIG_STATE, 8'd1, "loss_state_wait");
    expect_at(k + 18, SIG_CORE,  8'd1, "loss_core_wait");
    expect_at(k + 19, SIG_STATE, 8'd2, "loss_state_run");
    expect_at(k + 19, SIG_CORE,  8'd0, "loss_core_release");
    tick(10);
    init_ddr3_done = 1'b1;
    tick(25);

    // 5: saturation of the request counter, then a request restarting the hold
    for (int p = 0; p < 300; p++) begin
      jsys_reset = 1'b1;
      tick(4);
      jsys_reset = 1'b0;
      tick(4);
    end
    expect_at(cyc + 2, SIG_CNT, 8'd255, "sat_count");
    c = cyc;
    jsys_reset = 1'b1;
    expect_at(c + 22, SIG_STATE, 8'd0, "glitch_no_early_wait");
    expect_at(c + 35, SIG_STATE, 8'd0, "glitch_hold_end");
    expect_at(c + 36, SIG_STATE, 8'd1, "glitch_state_wait");
    expect_at(c + 36, SIG_CNT,   8'd255, "glitch_count_sat");
    expect_at(c + 37, SIG_STATE, 8'd1, "glitch_stay_wait");
    expect_at(c + 99, SIG_TMO,   8'd0, "t6_tmo_not_yet");
    expect_at(c + 100, SIG_TMO,  8'd1, "t6_tmo_set");
    expect_at(c + 100, SIG_CORE, 8'd1, "t6_core_held");
    tick(4);
    jsys_reset = 1'b0;
    tick(10);
    jsys_reset     = 1'b1;
    init_ddr3_done = 1'b0;
    tick(4);
    jsys_reset = 1'b0;
    tick(c + 105 - cyc);

    // 6: asynchronous reset in WAIT_DDR with the timeout flag set
    sys_rst_n = 1'b0;
    #2;
    compare("async_core",  {7'd0, core_reset},  8'd1);
    compare("async_state", {6'd0, sys_state},   8'd0);
    compare("async_tmo",   {7'd0, ddr_timeout}, 8'd0);
    compare("async_count", reset_count,          8'd0);
    init_ddr3_done = 1'b1;
    tick(1);
    sys_rst_n = 1'b1;
    c0 = cyc;
    expect_powerup(c0, "pwr2");
    tick(22);

    compare("scoreboard_drained", 8'(sb.size()), 8'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
